// File: rtl/instr_fetch.sv
// Warthog instruction fetch: owns the PC, reads the combinational ROM one word per cycle
// and feeds the decoder through a 2-entry prefetch buffer with branch redirect and halt.
module instr_fetch #(
    parameter int unsigned           ADDR_W   = 8,
    parameter int unsigned           INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt
);

    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] buf_instr [2];
    logic [ADDR_W-1:0]  buf_pc    [2];
    logic [1:0]         count;
    logic               pop;
    logic               fetch;
    logic               wr_slot;

    always_comb begin
        instr_valid = (count != 2'd0);
        instr       = instr_valid ? buf_instr[0] : '0;
        instr_pc    = instr_valid ? buf_pc[0]    : '0;
        rom_addr    = pc;
        pop         = instr_valid && instr_ready;
        fetch       = !halt && !branch_valid && ((count < 2'd2) || pop);
        // Entry 0 is always the head; a push lands just behind whatever survives the pop.
        wr_slot     = (count == 2'd2) || ((count == 2'd1) && !pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            count <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (branch_valid) begin
            pc    <= branch_target;
            count <= '0;
        end else begin
            if (pop) begin
                buf_instr[0] <= buf_instr[1];
                buf_pc[0]    <= buf_pc[1];
            end
            if (fetch) begin
                pc                <= pc + 1'b1;
                buf_instr[wr_slot] <= rom_data;
                buf_pc[wr_slot]    <= pc;
            end
            case ({fetch, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector table, hand-written reset sequence,
// and a randomised ready/halt stream checked against an in-order expected-word queue.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch_valid = 1'b0;
    logic [7:0]  branch_target = '0;
    logic        halt = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [7:0] a);
        case (a)
            8'h00:   return 16'hC000;
            8'h01:   return 16'hC801;
            8'h02:   return 16'hD002;
            8'h0F:   return 16'hB9F1;
            8'hFF:   return 16'h1234;
            default: return 16'h0000;
        endcase
    endfunction

    assign rom_data = rom_f(rom_addr);

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt          (halt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        bv;
        logic [7:0]  bt;
        logic        halt;
        logic        ev;
        logic [15:0] ei;
        logic [7:0]  ep;
        logic [7:0]  ea;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rd, input logic b, input logic [7:0] t,
                       input logic h, input logic v, input logic [15:0] i,
                       input logic [7:0] p, input logic [7:0] a);
        vec_t x;
        x.rst = r; x.ready = rd; x.bv = b; x.bt = t; x.halt = h;
        x.ev = v; x.ei = i; x.ep = p; x.ea = a;
        vecs.push_back(x);
    endtask

    typedef struct packed {
        logic [15:0] i;
        logic [7:0]  p;
    } exp_t;

    exp_t sbq[$];

    initial begin
        int delivered;
        exp_t e;

        // Fields: rst ready bv bt halt | expected valid instr pc rom_addr (outputs during the row's cycle)
        // Straight-line streaming from reset
        add(1,1,0,8'h00,0, 0,16'h0000,8'h00,8'h00);
        add(0,1,0,8'h00,0, 0,16'h0000,8'h00,8'h00);
        add(0,1,0,8'h00,0, 1,16'hC000,8'h00,8'h01);
        add(0,1,0,8'h00,0, 1,16'hC801,8'h01,8'h02);
        add(0,1,0,8'h00,0, 1,16'hD002,8'h02,8'h03);
        add(0,1,0,8'h00,0, 1,16'h0000,8'h03,8'h04);
        // Decoder stall for 5 cycles, then back-to-back delivery
        add(1,0,0,8'h00,0, 0,16'h0000,8'h00,8'h00);
        add(0,0,0,8'h00,0, 0,16'h0000,8'h00,8'h00);
        add(0,0,0,8'h00,0, 1,16'hC000,8'h00,8'h01);
        add(0,0,0,8'h00,0, 1,16'hC000,8'h00,8'h02);
        add(0,0,0,8'h00,0, 1,16'hC000,8'h00,8'h02);
        add(0,0,0,8'h00,0, 1,16'hC000,8'h00,8'h02);
        add(0,1,0,8'h00,0, 1,16'hC000,8'h00,8'h02);
        add(0,1,0,8'h00,0, 1,16'hC801,8'h01,8'h03);
        add(0,1,0,8'h00,0, 1,16'hD002,8'h02,8'h04);
        // Branch to 0F while head is pc 01
        add(1,1,0,8'h00,0, 0,16'h0000,8'h00,8'h00);
        add(0,1,0,8'h00,0, 0,16'h0000,8'h00,8'h00);
        add(0,1,0,8'h00,0, 1,16'hC000,8'h00,8'h01);
        add(0,1,1,8'h0F,0, 1,16'hC801,8'h01,8'h02);
        add(0,1,0,8'h00,0, 0,16'h0000,8'h00,8'h0F);
        add(0,1,0,8'h00,0, 1,16'hB9F1,8'h0F,8'h10);
        // Branch to FF and wrap to 00
        add(0,1,1,8'hFF,0, 1,16'h0000,8'h10,8'h11);
        add(0,1,0,8'h00,0, 0,16'h0000,8'h00,8'hFF);
        add(0,1,0,8'h00,0, 1,16'h1234,8'hFF,8'h00);
        add(0,1,0,8'h00,0, 1,16'hC000,8'h00,8'h01);
        add(0,0,0,8'h00,0, 1,16'hC801,8'h01,8'h02);
        // Halt with a full buffer drains two entries, pc frozen, then resumes
        add(0,1,0,8'h00,1, 1,16'hC801,8'h01,8'h03);
        add(0,1,0,8'h00,1, 1,16'hD002,8'h02,8'h03);
        add(0,1,0,8'h00,1, 0,16'h0000,8'h00,8'h03);
        add(0,1,0,8'h00,0, 0,16'h0000,8'h00,8'h03);
        // Branch during halt still redirects and flushes
        add(0,1,1,8'h0F,1, 1,16'h0000,8'h03,8'h04);
        add(0,1,0,8'h00,1, 0,16'h0000,8'h00,8'h0F);
        add(0,1,0,8'h00,0, 0,16'h0000,8'h00,8'h0F);
        add(0,1,0,8'h00,0, 1,16'hB9F1,8'h0F,8'h10);

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            rst           = vecs[k].rst;
            instr_ready   = vecs[k].ready;
            branch_valid  = vecs[k].bv;
            branch_target = vecs[k].bt;
            halt          = vecs[k].halt;
            @(negedge clk);
            chk($sformatf("row%0d_valid", k), {31'd0, instr_valid}, {31'd0, vecs[k].ev});
            chk($sformatf("row%0d_instr", k), {16'd0, instr},       {16'd0, vecs[k].ei});
            chk($sformatf("row%0d_pc", k),    {24'd0, instr_pc},    {24'd0, vecs[k].ep});
            chk($sformatf("row%0d_addr", k),  {24'd0, rom_addr},    {24'd0, vecs[k].ea});
        end

        // Asynchronous reset mid-cycle, with a branch pending, clears immediately
        @(posedge clk); #1;
        instr_ready   = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 8'hFF;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_rst_instr", {16'd0, instr},       32'd0);
        chk("async_rst_pc",    {24'd0, instr_pc},    32'd0);
        chk("async_rst_addr",  {24'd0, rom_addr},    32'd0);
        @(posedge clk); #1;
        rst          = 1'b0;
        branch_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_rst_addr",  {24'd0, rom_addr},    32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("restart_valid", {31'd0, instr_valid}, 32'd1);
        chk("restart_instr", {16'd0, instr},       32'h0000C000);
        chk("restart_pc",    {24'd0, instr_pc},    32'd0);

        // Random ready/halt: delivered stream must be ROM words in strict PC order
        @(posedge clk); #1;
        rst = 1'b1;
        instr_ready = 1'b0;
        halt = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int a = 0; a < 256; a++) begin
            e.i = rom_f(8'(a));
            e.p = 8'(a);
            sbq.push_back(e);
        end
        delivered = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            instr_ready = ($urandom_range(0, 3) != 0);
            halt        = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow actual=extra_word required=none");
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("sb%0d_instr", delivered), {16'd0, instr},    {16'd0, e.i});
                    chk($sformatf("sb%0d_pc", delivered),    {24'd0, instr_pc}, {24'd0, e.p});
                end
                delivered++;
            end
        end
        chk("sb_progress", {31'd0, (delivered >= 60)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 16-bit Warthog core: owns the program counter, reads the combinational instruction ROM one word per cycle, and hands instructions to the decoder over a valid/ready handshake. A 2-entry prefetch buffer absorbs decoder stalls without losing fetch throughput. It accepts branch redirects from execute, which flush the buffer. It sits between the instruction ROM (8-bit address, 16-bit data) and the decode stage.

## Interface
- ADDR_W, 8, instruction address width; PC wraps modulo 2^ADDR_W
- INSTR_W, 16, instruction word width
- RESET_PC, 8'h00, PC value loaded on reset
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rom_addr  output  ADDR_W  address to instruction ROM, always equals current PC
- rom_data  input  INSTR_W  ROM word for rom_addr, combinational, valid in the same cycle
- instr  output  INSTR_W  instruction at head of prefetch buffer
- instr_pc  output  ADDR_W  address the head instruction was fetched from
- instr_valid  output  1  head entry present
- instr_ready  input  1  decoder accepts head this cycle
- branch_valid  input  1  redirect request, one-cycle pulse
- branch_target  input  ADDR_W  new PC when branch_valid high
- halt  input  1  level; suppresses fetch while high, buffer still drains

## Operation
- State: pc (ADDR_W), 2-entry buffer of {instr, pc} pairs, count 0..2.
- pop = instr_valid && instr_ready.
- fetch = !halt && !branch_valid && (count < 2 || pop).
- On fetch: push {rom_data, pc}; pc <= pc + 1, wrapping 8'hFF -> 8'h00 with no flag.
- count next = count + fetch - pop; a push and pop in the same cycle at count 2 is legal and keeps count at 2.
- Branch (branch_valid high): highest priority. Buffer flushed (count <= 0), pc <= branch_target, no push that cycle; a simultaneous pop is still consumed by the decoder but has no further effect on state.
- Halt: fetch suppressed and pc frozen; buffered entries continue to be presented and popped. A branch during halt still redirects pc and flushes.
- instr/instr_pc hold their values while instr_valid && !instr_ready (no change under back-pressure).
- Outputs when count == 0: instr_valid = 0; instr and instr_pc = 0.
- The block never reads or modifies rom_data contents; it does not decode instructions.

## Timing
- Reset (async, immediate): pc = RESET_PC, count = 0, instr_valid = 0, instr = 0, instr_pc = 0, rom_addr = RESET_PC.
- First edge after rst deasserts pushes ROM[RESET_PC]; instr_valid = 1 in the following cycle (1-cycle fetch latency).
- Steady state with instr_ready held high: one instruction per cycle, sequential PCs, no bubbles.
- Branch sampled at edge N: instr_valid = 0 during cycle N+1 and rom_addr = branch_target; ROM[branch_target] presented with instr_valid = 1 in cycle N+2 (2-cycle redirect penalty).
- Decoder stall: after instr_ready drops, at most 2 words are buffered, then pc stops advancing; resuming instr_ready gives back-to-back delivery with no bubble.
- Reset asserted mid-operation clears everything asynchronously, including a pending branch; no partial entries survive.
- halt rising: no push at that edge; halt falling: fetch resumes at the next edge from the frozen pc.

## Test plan
- Bench ROM model: ROM[00]=16'hC000, ROM[01]=16'hC801, ROM[02]=16'hD002, ROM[0F]=16'hB9F1, ROM[FF]=16'h1234, others 16'h0000.
- Reset release, instr_ready=1 -> cycle 1 instr=16'hC000/instr_pc=00, cycle 2 instr=16'hC801/pc=01, cycle 3 16'hD002/pc=02, no gaps.
- instr_ready=0 for 5 cycles from reset -> instr stays 16'hC000, rom_addr stops at 02; ready=1 -> 16'hC000, 16'hC801, 16'hD002 on consecutive cycles.
- branch_valid with target 0F while head is pc=01 -> next cycle instr_valid=0; following cycle instr=16'hB9F1, instr_pc=0F; pc=02 never delivered.
- Branch to FF, ready=1 -> 16'h1234/pc=FF then 16'hC000/pc=00 (wrap-around).
- halt=1 with count=2, ready=1 -> two pops then instr_valid=0, rom_addr frozen; rst pulse mid-stream -> instr_valid=0 immediately, restart at pc=00.
